// File: rtl/norm_approx_mult_pkg.sv
//------------------------------------------------------------------------------
// norm_approx_mult_pkg : FSM state type and width helpers for norm_approx_mult
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package norm_approx_mult_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NORM  = 3'd1,
      ST_MULT  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic int cnt_width(input int n);
      return $clog2(2 * n);
   endfunction

   function automatic int prod_width(input int k);
      return 2 * k;
   endfunction

   function automatic bit params_ok(input int n, input int k);
      return (n >= 4) && (k >= 2) && (2 * k <= n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/norm_approx_mult_lead_norm_reg.sv
//------------------------------------------------------------------------------
// lead_norm_reg : loadable left-normalising shift register with MSB flag and
//                 saturating shift counter.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lead_norm_reg #(
   parameter  int N  = 16,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [N-1:0]  i_d,
   input  logic          i_shift,
   output logic [N-1:0]  o_q,
   output logic          o_msb,
   output logic [SW-1:0] o_cnt
);

   logic [N-1:0]  r_q;
   logic [SW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q   <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_q   <= i_d;
         r_cnt <= '0;
      end else if (i_shift && !r_q[N-1]) begin
         r_q <= r_q << 1;
         if (r_cnt != '1)
            r_cnt <= r_cnt + SW'(1);
      end
   end

   assign o_q   = r_q;
   assign o_msb = r_q[N-1];
   assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/norm_approx_mult.sv
//------------------------------------------------------------------------------
// norm_approx_mult : self-sequenced normalise / K-bit multiply / denormalise
//   approximate multiplier. Optional macro NORM_APPROX_MULT_ROUND_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module norm_approx_mult
   import norm_approx_mult_pkg::*;
#(
   parameter int N = 16,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] inp_1,
   input  logic [N-1:0] inp_2,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         exact
);

   localparam int CW  = cnt_width(N);
   localparam int PW  = prod_width(K);
   localparam int PAD = N - PW;
   localparam int SW  = $clog2(N);

   if (!params_ok(N, K)) begin : g_param_check
      $error("norm_approx_mult: requires N >= 4 and 2 <= K <= N/2");
   end

   state_t         r_state, w_next;
   logic [N-1:0]   w_ra, w_rb;
   logic           w_msb_a, w_msb_b;
   logic [SW-1:0]  w_sa, w_sb;
   logic           w_load, w_norm, w_zero_op;
   logic [K-1:0]   w_ma, w_mb;
   logic [PW-1:0]  w_prod;
   logic [N-1:0]   w_prod_al, w_final;
   logic [N-1:0]   r_acc, r_result;
   logic [CW-1:0]  r_cnt;
   logic           r_exact_m, r_exact;

   assign w_load    = (r_state == ST_IDLE) && start;
   assign w_norm    = (r_state == ST_NORM);
   assign w_zero_op = (inp_1 == '0) || (inp_2 == '0);

   lead_norm_reg #(.N(N)) u_norm_a (
      .clk(clk), .rst(rst), .i_load(w_load), .i_d(inp_1), .i_shift(w_norm),
      .o_q(w_ra), .o_msb(w_msb_a), .o_cnt(w_sa)
   );

   lead_norm_reg #(.N(N)) u_norm_b (
      .clk(clk), .rst(rst), .i_load(w_load), .i_d(inp_2), .i_shift(w_norm),
      .o_q(w_rb), .o_msb(w_msb_b), .o_cnt(w_sb)
   );

   assign w_ma      = w_ra[N-1 -: K];
   assign w_mb      = w_rb[N-1 -: K];
   assign w_prod    = {{K{1'b0}}, w_ma} * {{K{1'b0}}, w_mb};
   assign w_prod_al = N'(w_prod) << PAD;

`ifdef NORM_APPROX_MULT_ROUND_EN
   logic         r_lost;
   logic [N:0]   w_sum;

   // Round half-up on the last bit shifted out, clamped to all-ones
   assign w_sum   = {1'b0, r_acc} + (N+1)'(r_lost);
   assign w_final = w_sum[N] ? '1 : w_sum[N-1:0];

   always_ff @(posedge clk) begin
      if (!rst)
         r_lost <= 1'b0;
      else if (r_state == ST_MULT)
         r_lost <= 1'b0;
      else if (r_state == ST_SHIFT && r_cnt != '0)
         r_lost <= r_acc[0];
   end
`else
   assign w_final = r_acc;
`endif

   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = w_zero_op ? ST_DONE : ST_NORM;
         ST_NORM:  if (w_msb_a && w_msb_b) w_next = ST_MULT;
         ST_MULT:  w_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == '0) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_exact_m <= 1'b0;
         r_result  <= '0;
         r_exact   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && w_zero_op) begin
                  r_result <= '0;
                  r_exact  <= 1'b1;
               end
            end
            ST_MULT: begin
               r_acc     <= w_prod_al;
               r_cnt     <= CW'(w_sa) + CW'(w_sb);
               r_exact_m <= (w_ra[N-K-1:0] == '0) && (w_rb[N-K-1:0] == '0);
            end
            ST_SHIFT: begin
               if (r_cnt == '0) begin
                  r_result <= w_final;
                  r_exact  <= r_exact_m;
               end else begin
                  r_acc <= r_acc >> 1;
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign exact  = r_exact;

endmodule

`default_nettype wire
